// File: rtl/panda_pcap_pkg.sv
// panda_pcap_pkg: shared state encodings and disarm reason codes for pcap arming
package panda_pcap_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLUSH   = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_ENABLED = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [3:0] R_NONE       = 4'd0;
  localparam logic [3:0] R_USER       = 4'd1;
  localparam logic [3:0] R_WINLIM     = 4'd2;
  localparam logic [3:0] R_FLUSH_TO   = 4'd3;
  localparam logic [3:0] R_ABORT_BASE = 4'd8;
  function automatic logic [3:0] abort_reason(input logic [2:0] k);
    return R_ABORT_BASE | {1'b0, k};
  endfunction
endpackage

// File: rtl/panda_pcap_abort_enc.sv
// panda_pcap_abort_enc: any-abort flag plus reason code of the lowest set abort source
module panda_pcap_abort_enc
  import panda_pcap_pkg::*;
#(
  parameter int NUM_ABORT = 4
) (
  input  logic [NUM_ABORT-1:0] abort_i,
  output logic                 any_o,
  output logic [3:0]           reason_o
);
  logic [2:0] idx;
  always_comb begin
    idx = '0;
    for (int i = NUM_ABORT - 1; i >= 0; i--) if (abort_i[i]) idx = 3'(i);
    any_o    = |abort_i;
    reason_o = abort_reason(idx);
  end
endmodule

// File: rtl/panda_pcap_arm_ctrl.sv
// panda_pcap_arm_ctrl: arm/flush/multi-window enable/drain controller with encoded disarm reason
module panda_pcap_arm_ctrl
  import panda_pcap_pkg::*;
#(
  parameter int NUM_ABORT     = 4,
  parameter int FLUSH_MIN     = 4,
  parameter int FLUSH_TIMEOUT = 1000,
  parameter int WIN_W         = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  input  logic                 enable_i,
  input  logic [NUM_ABORT-1:0] abort_i,
  input  logic                 ongoing_capture_i,
  input  logic                 dma_fifo_ready_i,
  input  logic [WIN_W-1:0]     max_windows_i,
  output logic                 dma_fifo_reset_o,
  output logic                 pcap_armed_o,
  output logic                 pcap_enabled_o,
  output logic                 pcap_done_o,
  output logic [WIN_W-1:0]     window_count_o,
  output logic [3:0]           disarm_reason_o
);
  localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CW-1:0] FMIN_C = CW'(FLUSH_MIN);
  localparam logic [CW-1:0] FLAST_C = CW'(FLUSH_TIMEOUT - 1);
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    flush_q, flush_d;
  logic [WIN_W-1:0] win_q, win_d, lim_q, lim_d;
  logic [3:0]       reason_q, reason_d;
  logic             fifo_q, armed_q, enabled_q, done_q;
  logic             abort_any, at_limit;
  logic [3:0]       abort_rsn;
  panda_pcap_abort_enc #(.NUM_ABORT(NUM_ABORT)) u_abort_enc (
    .abort_i (abort_i),
    .any_o   (abort_any),
    .reason_o(abort_rsn)
  );
  assign at_limit = (lim_q != '0) && (win_q == lim_q);
  // Each stop path leaves the run, so a reason is only ever written once per arm.
  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    win_d    = win_q;
    lim_d    = lim_q;
    flush_d  = (state_q == S_FLUSH) ? flush_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: if (arm_i && !disarm_i) begin
        state_d  = S_FLUSH;
        reason_d = R_NONE;
        win_d    = '0;
        lim_d    = max_windows_i;
      end
      S_FLUSH: begin
        if (abort_any) begin
          state_d  = S_IDLE;
          reason_d = abort_rsn;
        end else if (disarm_i) begin
          state_d  = S_IDLE;
          reason_d = R_USER;
        end else if (flush_q >= FMIN_C && dma_fifo_ready_i) begin
          state_d = S_ARMED;
        end else if (flush_q == FLAST_C) begin
          state_d  = S_IDLE;
          reason_d = R_FLUSH_TO;
        end
      end
      S_ARMED, S_ENABLED: begin
        if (abort_any) begin
          state_d  = S_DRAIN;
          reason_d = abort_rsn;
        end else if (disarm_i) begin
          state_d  = S_DRAIN;
          reason_d = R_USER;
        end else if (state_q == S_ARMED && enable_i) begin
          state_d = S_ENABLED;
          win_d   = &win_q ? win_q : win_q + 1'b1;
        end else if (state_q == S_ENABLED && !enable_i) begin
          state_d  = at_limit ? S_DRAIN : S_ARMED;
          reason_d = at_limit ? R_WINLIM : reason_q;
        end
      end
      S_DRAIN: if (!ongoing_capture_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      flush_q   <= '0;
      win_q     <= '0;
      lim_q     <= '0;
      reason_q  <= R_NONE;
      fifo_q    <= 1'b0;
      armed_q   <= 1'b0;
      enabled_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      win_q     <= win_d;
      lim_q     <= lim_d;
      reason_q  <= reason_d;
      fifo_q    <= (state_d == S_FLUSH) && (flush_d < FMIN_C);
      armed_q   <= state_d inside {S_ARMED, S_ENABLED, S_DRAIN};
      enabled_q <= state_d == S_ENABLED;
      done_q    <= (state_q == S_DRAIN) && (state_d == S_IDLE);
    end
  end
  assign dma_fifo_reset_o = fifo_q;
  assign pcap_armed_o     = armed_q;
  assign pcap_enabled_o   = enabled_q;
  assign pcap_done_o      = done_q;
  assign window_count_o   = win_q;
  assign disarm_reason_o  = reason_q;
endmodule
